// File: rtl/rf_writeback_ctrl_pkg.sv
// Shared widths and queue entry type for the register-file write-back slice.
package rf_writeback_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned NUM_REGS   = 16;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     data_t;

  typedef struct packed {
    logic      live;
    reg_addr_t rd;
    data_t     data;
  } lq_entry_t;

  function automatic logic [NUM_REGS-1:0] onehot_reg(input reg_addr_t r);
    return NUM_REGS'(1) << r;
  endfunction

endpackage

// File: rtl/rf_load_queue.sv
// Circular load-result FIFO with per-entry live bit, squash-by-rd and pending mask.
module rf_load_queue
  import rf_writeback_ctrl_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  reg_addr_t           push_rd_i,
  input  data_t               push_data_i,
  input  logic                pop_i,
  input  logic                squash_i,
  input  reg_addr_t           squash_rd_i,
  output logic                full_o,
  output logic                empty_o,
  output lq_entry_t           head_o,
  output logic [NUM_REGS-1:0] pend_mask_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  lq_entry_t       mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  logic            push, pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign push    = push_i && !full_o;
  assign pop     = pop_i && !empty_o;
  assign head_o  = mem_q[rptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (squash_i && mem_q[i].rd == squash_rd_i) mem_q[i].live <= 1'b0;
      end
      // Popped slots drop live so pend_mask only ever sees occupied entries.
      if (pop) begin
        mem_q[rptr_q].live <= 1'b0;
        rptr_q             <= rptr_q + PtrW'(1);
      end
      if (push) begin
        mem_q[wptr_q] <= '{live: !(squash_i && push_rd_i == squash_rd_i),
                           rd:   push_rd_i,
                           data: push_data_i};
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
    end
  end

  always_comb begin
    pend_mask_o = '0;
    for (int i = 0; i < Depth; i++) begin
      if (mem_q[i].live) pend_mask_o = pend_mask_o | onehot_reg(mem_q[i].rd);
    end
  end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Merges ALU and queued load results onto the single register-file write port,
// ALU first with a bounded-starvation drain slot for the load queue.
module rf_writeback_ctrl
  import rf_writeback_ctrl_pkg::*;
#(
  parameter int unsigned LQ_DEPTH   = 4,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0]     alu_data,
  output logic                  alu_stall,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0]     ld_data,
  output logic [REG_ADDR_W-1:0] Rd,
  output logic [DATA_W-1:0]     RW,
  output logic                  wr,
  output logic [NUM_REGS-1:0]   pend_mask
);

  localparam int unsigned StW = $clog2(STARVE_MAX + 1);

  logic           lq_full, lq_empty;
  lq_entry_t      head;
  logic           alu_win, drain;
  logic [StW-1:0] starve_q, starve_d;
  logic           stall_d;

  // A stalled ALU never wins; any alu_valid during stall is dropped.
  assign alu_win  = alu_valid && !alu_stall;
  assign drain    = !lq_empty && !alu_win;
  assign ld_ready = !lq_full;

  rf_load_queue #(
    .Depth(LQ_DEPTH)
  ) u_load_queue (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (ld_valid),
    .push_rd_i   (ld_rd),
    .push_data_i (ld_data),
    .pop_i       (drain),
    .squash_i    (alu_win),
    .squash_rd_i (alu_rd),
    .full_o      (lq_full),
    .empty_o     (lq_empty),
    .head_o      (head),
    .pend_mask_o (pend_mask)
  );

  always_comb begin
    starve_d = starve_q;
    stall_d  = 1'b0;
    if (lq_empty || drain) begin
      starve_d = '0;
    end else if (alu_win) begin
      if (starve_q == StW'(STARVE_MAX - 1)) begin
        stall_d  = 1'b1;
        starve_d = '0;
      end else begin
        starve_d = starve_q + StW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Rd        <= '0;
      RW        <= '0;
      wr        <= 1'b0;
      alu_stall <= 1'b0;
      starve_q  <= '0;
    end else begin
      starve_q  <= starve_d;
      alu_stall <= stall_d;
      wr        <= alu_win || (drain && head.live);
      if (alu_win) begin
        Rd <= alu_rd;
        RW <= alu_data;
      end else if (drain && head.live) begin
        Rd <= head.rd;
        RW <= head.data;
      end
    end
  end

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Randomised and directed bench for rf_writeback_ctrl against a queue-based reference model.
module tb_rf_writeback_ctrl;

  localparam int unsigned LQ_DEPTH   = 4;
  localparam int unsigned STARVE_MAX = 3;

  typedef struct {
    logic [3:0]  rd;
    logic [15:0] data;
    bit          live;
  } mentry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid = 1'b0, ld_valid = 1'b0;
  logic [3:0]  alu_rd = '0, ld_rd = '0;
  logic [15:0] alu_data = '0, ld_data = '0;
  logic        alu_stall, ld_ready, wr;
  logic [3:0]  Rd;
  logic [15:0] RW;
  logic [15:0] pend_mask;

  int checks = 0;
  int errors = 0;

  mentry_t     m_q[$];
  int          m_starve;
  bit          m_stall, m_wr;
  logic [3:0]  m_rd;
  logic [15:0] m_rw;
  logic [15:0] ld_log[$];

  rf_writeback_ctrl #(
    .LQ_DEPTH  (LQ_DEPTH),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_stall (alu_stall),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .Rd        (Rd),
    .RW        (RW),
    .wr        (wr),
    .pend_mask (pend_mask)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) assert (!(alu_valid && alu_stall)) else $error("alu_valid driven during alu_stall");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_pend();
    logic [15:0] m = '0;
    foreach (m_q[i]) if (m_q[i].live) m[m_q[i].rd] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_starve = 0;
    m_stall  = 0;
    m_wr     = 0;
    m_rd     = '0;
    m_rw     = '0;
  endtask

  // One clock of spec behaviour, evaluated on the pre-edge model state.
  task automatic model_step(input bit av, input logic [3:0] ard, input logic [15:0] adat,
                            input bit lv, input logic [3:0] lrd, input logic [15:0] ldat);
    bit win, nonempty, drain, push, next_stall;
    win      = av && !m_stall;
    nonempty = m_q.size() > 0;
    drain    = nonempty && !win;
    push     = lv && (m_q.size() < LQ_DEPTH);
    next_stall = 0;
    if (!nonempty || drain) m_starve = 0;
    else if (win) begin
      m_starve++;
      if (m_starve == STARVE_MAX) begin
        next_stall = 1;
        m_starve   = 0;
      end
    end
    m_wr = 0;
    if (win) begin
      m_wr = 1; m_rd = ard; m_rw = adat;
    end else if (drain && m_q[0].live) begin
      m_wr = 1; m_rd = m_q[0].rd; m_rw = m_q[0].data;
    end
    if (drain) void'(m_q.pop_front());
    if (push) m_q.push_back('{rd: lrd, data: ldat, live: 1});
    if (win) foreach (m_q[i]) if (m_q[i].rd == ard) m_q[i].live = 0;
    m_stall = next_stall;
  endtask

  task automatic compare_all();
    check("wr", 32'(wr), 32'(m_wr));
    check("Rd", 32'(Rd), 32'(m_rd));
    check("RW", 32'(RW), 32'(m_rw));
    check("alu_stall", 32'(alu_stall), 32'(m_stall));
    check("ld_ready", 32'(ld_ready), 32'(m_q.size() < LQ_DEPTH));
    check("pend_mask", 32'(pend_mask), 32'(model_pend()));
  endtask

  task automatic cycle(input bit av, input logic [3:0] ard, input logic [15:0] adat,
                       input bit lv, input logic [3:0] lrd, input logic [15:0] ldat);
    alu_valid = av; alu_rd = ard; alu_data = adat;
    ld_valid  = lv; ld_rd  = lrd; ld_data  = ldat;
    model_step(av, ard, adat, lv, lrd, ldat);
    @(posedge clk);
    #1;
    compare_all();
    if (wr && RW[15:12] == 4'hC) ld_log.push_back(RW);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 4'h0, 16'h0, 0, 4'h0, 16'h0);
  endtask

  initial begin
    int guard;
    int pa;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b1;
    idle(2);

    // ALU only
    cycle(1, 4'd5, 16'hBEEF, 0, 4'h0, 16'h0);
    check("alu_rd5", 32'(Rd), 32'd5);
    check("alu_beef", 32'(RW), 32'hBEEF);
    check("alu_wr", 32'(wr), 32'd1);
    idle(1);
    check("alu_pulse", 32'(wr), 32'd0);

    // Load only
    cycle(0, 4'h0, 16'h0, 1, 4'd3, 16'h1234);
    check("ld_pend", 32'(pend_mask), 32'h0008);
    check("ld_nowr_t1", 32'(wr), 32'd0);
    idle(1);
    check("ld_wr_t2", 32'(wr), 32'd1);
    check("ld_rd3", 32'(Rd), 32'd3);
    check("ld_data", 32'(RW), 32'h1234);

    // WAW squash
    cycle(0, 4'h0, 16'h0, 1, 4'd7, 16'h5555);
    check("waw_pend_set", 32'(pend_mask), 32'h0080);
    cycle(1, 4'd7, 16'h00AA, 0, 4'h0, 16'h0);
    check("waw_alu_data", 32'(RW), 32'h00AA);
    check("waw_pend_clr", 32'(pend_mask), 32'h0000);
    idle(1);
    check("waw_squashed_nowr", 32'(wr), 32'd0);
    idle(1);

    // Full and starvation
    ld_log.delete();
    cycle(0, 4'h0, 16'h0, 1, 4'd1, 16'hC001);
    cycle(1, 4'hF, 16'hA000, 1, 4'd2, 16'hC002);
    cycle(1, 4'hF, 16'hA001, 1, 4'd3, 16'hC003);
    cycle(1, 4'hF, 16'hA002, 1, 4'd4, 16'hC004);
    check("full_ready", 32'(ld_ready), 32'd0);
    check("full_stall", 32'(alu_stall), 32'd1);
    guard = 0;
    while ((m_q.size() > 0) && guard < 60) begin
      cycle(!m_stall, 4'hF, 16'hA100 + 16'(guard), 0, 4'h0, 16'h0);
      guard++;
    end
    check("drain_bounded", 32'(guard < 60), 32'd1);
    idle(1);
    check("fifo_count", 32'(ld_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < ld_log.size()) check("fifo_order", 32'(ld_log[i]), 32'hC001 + i);
    end

    // Reset mid-traffic with three queued loads
    cycle(0, 4'h0, 16'h0, 1, 4'd8, 16'hC008);
    cycle(1, 4'hE, 16'hA200, 1, 4'd9, 16'hC009);
    cycle(1, 4'hE, 16'hA201, 1, 4'd10, 16'hC00A);
    check("pre_rst_pend", 32'(pend_mask), 32'h0700);
    alu_valid = 0; ld_valid = 0;
    rst = 1'b0;
    #1;
    model_reset();
    check("rst_async_wr", 32'(wr), 32'd0);
    check("rst_async_pend", 32'(pend_mask), 32'd0);
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b1;
    idle(3);

    // Random traffic in phases of varying ALU pressure
    for (int ph = 0; ph < 8; ph++) begin
      pa = 20 + ph * 10;
      for (int i = 0; i < 250; i++) begin
        cycle(!m_stall && ($urandom_range(0, 99) < pa), 4'($urandom_range(0, 7)),
              16'($urandom), $urandom_range(0, 99) < 55, 4'($urandom_range(0, 7)),
              16'($urandom));
      end
    end
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
